// File: rtl/uart_alu_ctrl_pkg.sv
// uart_alu_ctrl_pkg: shared widths, opcodes, FSM states and opcode check for the UART ALU sequencer
package uart_alu_ctrl_pkg;
    localparam int DEF_DATA_BITS = 8;
    localparam int DEF_OP_BITS   = 6;
    localparam logic [5:0] OP_ADD = 6'h20;
    localparam logic [5:0] OP_SUB = 6'h22;
    localparam logic [5:0] OP_AND = 6'h24;
    localparam logic [5:0] OP_OR  = 6'h25;
    localparam logic [5:0] OP_XOR = 6'h26;
    localparam logic [5:0] OP_SRA = 6'h03;
    localparam logic [5:0] OP_SRL = 6'h02;
    localparam logic [5:0] OP_NOR = 6'h27;
    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_B,
        S_WAIT_OP,
        S_EXEC,
        S_WAIT_TX
    } state_t;
    function automatic logic valid_op(input logic [5:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR};
    endfunction
endpackage

// File: rtl/uart_alu_ctrl_ifg_timer.sv
// ifg_timer: saturating inter-byte tick counter with clear, enable and terminal-count flag
module ifg_timer #(
    parameter int MAX = 16384
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic done
);
    localparam int W = $clog2(MAX + 1);
    logic [W-1:0] cnt;
    assign done = cnt == W'(MAX);
    always_ff @(posedge clk) begin
        if (rst || clr) cnt <= '0;
        else if (en && !done) cnt <= cnt + W'(1);
    end
endmodule

// File: rtl/uart_alu_ctrl.sv
// uart_alu_ctrl: collects A, B, opcode bytes, drives the ALU and sends one result byte, with inter-byte timeout
module uart_alu_ctrl
    import uart_alu_ctrl_pkg::*;
#(
    parameter int                   DATA_BITS = DEF_DATA_BITS,
    parameter int                   OP_BITS   = DEF_OP_BITS,
    parameter int                   TIMEOUT   = 16384,
    parameter logic [DATA_BITS-1:0] ERR_CODE  = '1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_tick,
    input  logic                 i_rx_done,
    input  logic [DATA_BITS-1:0] i_rx_data,
    input  logic [DATA_BITS-1:0] i_alu_result,
    input  logic                 i_tx_done,
    output logic [DATA_BITS-1:0] o_alu_a,
    output logic [DATA_BITS-1:0] o_alu_b,
    output logic [OP_BITS-1:0]   o_alu_op,
    output logic                 o_tx_start,
    output logic [DATA_BITS-1:0] o_tx_data,
    output logic                 o_busy,
    output logic                 o_timeout
);
    state_t state, state_n;
    logic [DATA_BITS-1:0] a_n, b_n, tx_data_n;
    logic [OP_BITS-1:0] op_n;
    logic tx_start_n, timeout_n, waiting, accept, expired;

    assign waiting = state == S_WAIT_B || state == S_WAIT_OP;
    assign accept  = i_rx_done && (state == S_IDLE || waiting);
    assign o_busy  = state != S_IDLE;

    ifg_timer #(.MAX(TIMEOUT)) u_timer (
        .clk (i_clk),
        .rst (i_reset),
        .clr (accept || state_n == S_IDLE),
        .en  (waiting && i_tick),
        .done(expired)
    );

    // A received byte in the expiry cycle takes precedence over the timeout
    always_comb begin
        state_n    = state;
        a_n        = o_alu_a;
        b_n        = o_alu_b;
        op_n       = o_alu_op;
        tx_data_n  = o_tx_data;
        tx_start_n = 1'b0;
        timeout_n  = 1'b0;
        case (state)
            S_IDLE: if (i_rx_done) begin
                a_n     = i_rx_data;
                state_n = S_WAIT_B;
            end
            S_WAIT_B: if (i_rx_done) begin
                b_n     = i_rx_data;
                state_n = S_WAIT_OP;
            end else if (expired) begin
                timeout_n = 1'b1;
                state_n   = S_IDLE;
            end
            S_WAIT_OP: if (i_rx_done) begin
                op_n    = i_rx_data[OP_BITS-1:0];
                state_n = S_EXEC;
            end else if (expired) begin
                timeout_n = 1'b1;
                state_n   = S_IDLE;
            end
            S_EXEC: begin
                tx_data_n  = valid_op(6'(o_alu_op)) ? i_alu_result : ERR_CODE;
                tx_start_n = 1'b1;
                state_n    = S_WAIT_TX;
            end
            S_WAIT_TX: state_n = i_tx_done ? S_IDLE : S_WAIT_TX;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= S_IDLE;
            o_alu_a    <= '0;
            o_alu_b    <= '0;
            o_alu_op   <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_timeout  <= 1'b0;
        end else begin
            state      <= state_n;
            o_alu_a    <= a_n;
            o_alu_b    <= b_n;
            o_alu_op   <= op_n;
            o_tx_data  <= tx_data_n;
            o_tx_start <= tx_start_n;
            o_timeout  <= timeout_n;
        end
    end
endmodule

// File: tb/tb_uart_alu_ctrl.sv
// tb_uart_alu_ctrl: table-driven frame checks plus timeout, stray-byte and reset sequences
module tb_uart_alu_ctrl;
    localparam int TO = 32;

    logic clk = 0;
    logic reset = 1;
    logic tick = 0;
    logic rx_done = 0;
    logic [7:0] rx_data = '0;
    logic [7:0] alu_result;
    logic tx_done = 0;
    logic [7:0] alu_a, alu_b, tx_data;
    logic [5:0] alu_op;
    logic tx_start, busy, timeout;

    int total = 0;
    int bad = 0;

    uart_alu_ctrl #(.TIMEOUT(TO)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_tick      (tick),
        .i_rx_done   (rx_done),
        .i_rx_data   (rx_data),
        .i_alu_result(alu_result),
        .i_tx_done   (tx_done),
        .o_alu_a     (alu_a),
        .o_alu_b     (alu_b),
        .o_alu_op    (alu_op),
        .o_tx_start  (tx_start),
        .o_tx_data   (tx_data),
        .o_busy      (busy),
        .o_timeout   (timeout)
    );

    always #10 clk = ~clk;

    always_comb begin
        case (alu_op)
            6'h20: alu_result = alu_a + alu_b;
            6'h22: alu_result = alu_a - alu_b;
            6'h24: alu_result = alu_a & alu_b;
            6'h25: alu_result = alu_a | alu_b;
            6'h26: alu_result = alu_a ^ alu_b;
            6'h03: alu_result = 8'($signed(alu_a) >>> alu_b);
            6'h02: alu_result = alu_a >> alu_b;
            6'h27: alu_result = ~(alu_a | alu_b);
            default: alu_result = 8'h5A;
        endcase
    end

    initial forever begin
        @(negedge clk);
        tick = !tick;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op;
        int         gap;
        bit         extra;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d);
        @(negedge clk);
        rx_data = d;
        rx_done = 1;
        @(negedge clk);
        rx_done = 0;
    endtask

    task automatic pulse_tx_done();
        tx_done = 1;
        @(negedge clk);
        tx_done = 0;
    endtask

    task automatic run_frame(input string nm, input vec_t v);
        int n;
        send_byte(v.a);
        repeat (v.gap) @(negedge clk);
        send_byte(v.b);
        repeat (v.gap) @(negedge clk);
        send_byte(v.op);
        n = 0;
        while (!tx_start && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_latency"}, n, 1);
        chk({nm, "_data"}, tx_data, v.exp);
        chk({nm, "_a"}, alu_a, v.a);
        chk({nm, "_b"}, alu_b, v.b);
        chk({nm, "_op"}, alu_op, v.op[5:0]);
        @(negedge clk);
        chk({nm, "_one_pulse"}, tx_start, 0);
        chk({nm, "_busy_tx"}, busy, 1);
        if (v.extra) begin
            send_byte(8'hAA);
            chk({nm, "_stray_busy"}, busy, 1);
            chk({nm, "_stray_a"}, alu_a, v.a);
            chk({nm, "_stray_data"}, tx_data, v.exp);
        end
        pulse_tx_done();
        chk({nm, "_idle"}, busy, 0);
    endtask

    initial begin
        int to_cnt, tx_cnt;
        tbl[0]  = '{8'h05, 8'h03, 8'h20, 0, 0, 8'h08};
        tbl[1]  = '{8'h05, 8'h07, 8'h22, 0, 0, 8'hFE};
        tbl[2]  = '{8'hF0, 8'h02, 8'h03, 0, 0, 8'hFC};
        tbl[3]  = '{8'h10, 8'h01, 8'h3F, 0, 0, 8'hFF};
        tbl[4]  = '{8'h0C, 8'h0A, 8'h25, 0, 0, 8'h0E};
        tbl[5]  = '{8'h0C, 8'h0A, 8'h26, 0, 0, 8'h06};
        tbl[6]  = '{8'hF0, 8'h02, 8'h02, 0, 0, 8'h3C};
        tbl[7]  = '{8'h0F, 8'hF0, 8'h27, 0, 0, 8'h00};
        tbl[8]  = '{8'h03, 8'h04, 8'hE0, 50, 0, 8'h07};
        tbl[9]  = '{8'h05, 8'h03, 8'h20, 0, 1, 8'h08};
        tbl[10] = '{8'h01, 8'h01, 8'h20, 0, 0, 8'h02};

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_a", alu_a, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_timeout", timeout, 0);
        reset = 0;

        for (int i = 0; i < 11; i++) run_frame($sformatf("f%0d", i), tbl[i]);

        send_byte(8'h01);
        pulse_tx_done();
        chk("to_txdone_ignored", busy, 1);
        send_byte(8'h02);
        chk("to_busy_wait_op", busy, 1);
        to_cnt = 0;
        tx_cnt = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (timeout) to_cnt++;
            if (tx_start) tx_cnt++;
        end
        chk("to_pulses", to_cnt, 1);
        chk("to_no_tx", tx_cnt, 0);
        chk("to_idle", busy, 0);
        run_frame("after_to", '{8'h04, 8'h04, 8'h24, 0, 0, 8'h04});

        send_byte(8'h07);
        send_byte(8'h08);
        chk("pre_rst_busy", busy, 1);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_a", alu_a, 0);
        chk("mid_rst_b", alu_b, 0);
        chk("mid_rst_op", alu_op, 0);
        chk("mid_rst_tx_data", tx_data, 0);
        chk("mid_rst_tx_start", tx_start, 0);
        chk("mid_rst_timeout", timeout, 0);
        reset = 0;
        run_frame("after_rst", '{8'h09, 8'h06, 8'h22, 0, 0, 8'h03});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
